// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer : command-driven step/seek/sweep/clear controller that
//                     drives a mod-11 prime/Fibonacci counter.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic       cmd_mode,
   input  logic       cmd_dir,
   input  logic [3:0] cmd_arg,
   input  logic       abort,
   output logic       ctr_en,
   output logic       ctr_up_down,
   output logic       ctr_prime_fib,
   output logic       ctr_clr_n,
   output logic [3:0] idx,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       aborted
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_CLR  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OP_STEP  = 2'd0;
   localparam logic [1:0] OP_SEEK  = 2'd1;
   localparam logic [1:0] OP_SWEEP = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   localparam logic [3:0] IDX_MAX   = 4'd10;
   localparam logic [3:0] IDX_COUNT = 4'd11;
   localparam logic [3:0] SEEK_HALF = 4'd5;

   logic [1:0] state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] rem_q, rem_d;
   logic       ctr_en_q, ctr_en_d;
   logic       ctr_up_down_q, ctr_up_down_d;
   logic       ctr_prime_fib_q, ctr_prime_fib_d;
   logic       ctr_clr_n_q, ctr_clr_n_d;
   logic       err_q, err_d;
   logic       aborted_q, aborted_d;

   logic [3:0] seek_dist;
   logic [3:0] idx_step;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= S_IDLE;
         idx_q           <= 4'd0;
         rem_q           <= 4'd0;
         ctr_en_q        <= 1'b0;
         ctr_up_down_q   <= 1'b1;
         ctr_prime_fib_q <= 1'b0;
         ctr_clr_n_q     <= 1'b1;
         err_q           <= 1'b0;
         aborted_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         rem_q           <= rem_d;
         ctr_en_q        <= ctr_en_d;
         ctr_up_down_q   <= ctr_up_down_d;
         ctr_prime_fib_q <= ctr_prime_fib_d;
         ctr_clr_n_q     <= ctr_clr_n_d;
         err_q           <= err_d;
         aborted_q       <= aborted_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      rem_d           = rem_q;
      ctr_en_d        = 1'b0;
      ctr_up_down_d   = ctr_up_down_q;
      ctr_prime_fib_d = ctr_prime_fib_q;
      ctr_clr_n_d     = 1'b1;
      err_d           = 1'b0;
      aborted_d       = 1'b0;

      // Forward distance mod 11; the 4-bit wrap of cmd_arg + 11 cancels out.
      if (cmd_arg >= idx_q) begin
         seek_dist = cmd_arg - idx_q;
      end else begin
         seek_dist = cmd_arg + IDX_COUNT - idx_q;
      end

      if (ctr_up_down_q) begin
         idx_step = (idx_q == IDX_MAX) ? 4'd0 : idx_q + 4'd1;
      end else begin
         idx_step = (idx_q == 4'd0) ? IDX_MAX : idx_q - 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               ctr_prime_fib_d = cmd_mode;
               case (cmd_op)
                  OP_STEP: begin
                     rem_d         = cmd_arg;
                     ctr_up_down_d = cmd_dir;
                     if (cmd_arg == 4'd0) begin
                        state_d = S_DONE;
                     end else begin
                        state_d  = S_RUN;
                        ctr_en_d = 1'b1;
                     end
                  end
                  OP_SEEK: begin
                     if (cmd_arg > IDX_MAX) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                     end else if (seek_dist == 4'd0) begin
                        state_d = S_DONE;
                     end else begin
                        state_d  = S_RUN;
                        ctr_en_d = 1'b1;
                        if (seek_dist <= SEEK_HALF) begin
                           rem_d         = seek_dist;
                           ctr_up_down_d = 1'b1;
                        end else begin
                           rem_d         = IDX_COUNT - seek_dist;
                           ctr_up_down_d = 1'b0;
                        end
                     end
                  end
                  OP_SWEEP: begin
                     rem_d         = IDX_COUNT;
                     ctr_up_down_d = cmd_dir;
                     state_d       = S_RUN;
                     ctr_en_d      = 1'b1;
                  end
                  default: begin
                     state_d     = S_CLR;
                     ctr_clr_n_d = 1'b0;
                  end
               endcase
            end
         end
         S_RUN: begin
            // The step enabled this cycle always lands, even on abort.
            idx_d = idx_step;
            rem_d = rem_q - 4'd1;
            if (abort || (rem_q == 4'd1)) begin
               state_d   = S_DONE;
               aborted_d = abort;
            end else begin
               ctr_en_d = 1'b1;
            end
         end
         S_CLR: begin
            idx_d   = 4'd0;
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      cmd_ready     = (state_q == S_IDLE) && rst;
      busy          = (state_q != S_IDLE);
      done          = (state_q == S_DONE);
      err           = err_q;
      aborted       = aborted_q;
      ctr_en        = ctr_en_q;
      ctr_up_down   = ctr_up_down_q;
      ctr_prime_fib = ctr_prime_fib_q;
      ctr_clr_n     = ctr_clr_n_q;
      idx           = idx_q;
   end

endmodule

`default_nettype wire

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller that sequences the prime/Fibonacci up/down counter. It accepts one command at a time over a valid/ready handshake and drives the counter's enable, direction, mode and clear inputs. It also keeps a mirror of the counter's mod-11 term index, so it can step N terms, seek a target index by the shortest path, sweep a full cycle, or clear. It sits between the system command source and the counter instance; the counter datapath is unchanged.

## Interface
- No parameters. Index range is fixed at 0..10 (mod-11).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset: asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 STEP, 01 SEEK, 10 SWEEP, 11 CLEAR.
- cmd_mode  in  1  1 = prime, 0 = Fibonacci; latched on accept.
- cmd_dir  in  1  1 = up, 0 = down; used by STEP and SWEEP only.
- cmd_arg  in  4  STEP: step count 0..15. SEEK: target index. SWEEP/CLEAR: ignored.
- abort  in  1  stop the current STEP/SEEK/SWEEP early.
- ctr_en  out  1  counter enable (registered).
- ctr_up_down  out  1  counter direction (registered).
- ctr_prime_fib  out  1  counter mode select (registered).
- ctr_clr_n  out  1  counter clear, active-low (registered). The top level drives the counter reset with rst & ctr_clr_n.
- idx  out  4  mirrored term index, 0..10.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse with done: SEEK target was out of range.
- aborted  out  1  one-cycle pulse with done: command ended by abort.

## Operation
- States are IDLE, RUN, CLR and DONE.
- Handshake:
  - cmd_ready = (state == IDLE) and rst high.
  - A command is accepted at an edge where cmd_valid & cmd_ready.
  - The command fields are don't-care at all other times.
- On accept, ctr_prime_fib ← cmd_mode (all ops) and a 4-bit remaining-step count rem is loaded.
- STEP:
  - rem ← cmd_arg; ctr_up_down ← cmd_dir.
  - rem = 0 goes directly to DONE.
- SEEK:
  - Forward distance d = cmd_arg − idx, plus 11 if cmd_arg < idx (4-bit result).
  - d ≤ 5: go up d steps. Otherwise go down 11 − d steps.
  - d = 0 goes to DONE with no steps.
  - cmd_arg > 10 goes to DONE with err = 1 and no steps.
- SWEEP: rem ← 11 in direction cmd_dir. The sequence ends on the starting index.
- CLEAR: next state is CLR.
- RUN:
  - ctr_en = 1 every cycle.
  - At each edge: rem ← rem − 1, and idx steps with wrap (up: 10→0, down: 0→10).
  - Leave for DONE at the edge where rem reaches 0.
- CLR: ctr_clr_n = 0 for exactly one cycle. At the end of that cycle idx ← 0, then go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Abort:
  - Sampled only in RUN.
  - At the edge where abort = 1, the step enabled in that cycle still counts.
  - Then go to DONE with aborted = 1 and ctr_en = 0.
  - Ignored in IDLE, CLR and DONE.
- Outside RUN, ctr_en = 0. ctr_up_down and ctr_prime_fib hold their last values.

## Timing
- Reset values (immediate on rst low):
  - state = IDLE, idx = 0, rem = 0.
  - ctr_en = 0, ctr_up_down = 1, ctr_prime_fib = 0, ctr_clr_n = 1.
  - cmd_ready = 0, busy = 0, done = 0, err = 0, aborted = 0.
- A reset in the middle of an operation discards the command. No done pulse is issued.
- N-step operation accepted at edge E0:
  - ctr_en is high from E0 to E0+N (N cycles).
  - idx updates at edges E0+1 … E0+N.
  - done is high in the cycle E0+N … E0+N+1.
  - cmd_ready returns at E0+N+1.
- Zero-step or err command: done is high in the cycle after accept.
- CLEAR:
  - ctr_clr_n is low for cycle E0 … E0+1.
  - done is high E0+1 … E0+2.
  - idx = 0 from E0+1.
- Throughput is one command per N+2 cycles. No overlap or queueing.
- idx always equals the counter's internal index at every edge.

## Test plan
- Reset, then STEP up 3, prime mode:
  - ctr_en is high for 3 cycles; idx = 3.
  - done occurs 4 cycles after accept.
  - Counter output = 7.
- From idx 0, SEEK 9, Fibonacci mode:
  - Two steps down (d = 9 > 5); idx = 9.
  - Counter output = 34; err = 0.
- From idx 4, SWEEP down:
  - Exactly 11 ctr_en cycles; idx returns to 4.
  - done on the 12th cycle.
- STEP up 10 with abort raised during the 2nd RUN cycle:
  - idx = 2; done and aborted pulse together.
  - No further ctr_en.
- SEEK 12:
  - done + err the next cycle, with no ctr_en.
- Then CLEAR from idx 7:
  - ctr_clr_n is low for 1 cycle; idx = 0.
  - Prime output = 2.
- rst pulled low in the 3rd cycle of a SWEEP:
  - All outputs take their reset values immediately.
  - No done pulse.
  - After release, cmd_ready = 1 and idx = 0.
